btb_predictor: RTL and testbench

- Fetch-side branch predictor: branch target buffer (BTB) plus per-entry 2-bit saturating counters.
- Produces `prediction` and `pre_pc` for the fetch stage. These are the signals the EX-stage correctness checker compares against the resolved outcome.
- Trained from that resolve point through the update port (`taken`, resolved target, `is_incorrect`).
- Also keeps a running mispredict count for performance reporting.

---
 rtl/btb_if.sv | 16 +
 rtl/btb_predictor.sv | 69 ++++++
 tb/tb_btb_predictor.sv | 105 ++++++++++
 3 files changed

// File: rtl/btb_if.sv
// btb_if: fetch lookup and resolve-time update/report signals of the branch predictor
interface btb_if;
  logic [31:0] fetch_pc;
  logic        prediction;
  logic [31:0] pre_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        taken;
  logic [31:0] target_pc;
  logic        is_incorrect;
  logic [31:0] mispredict_cnt;
  modport master (output fetch_pc, update_en, update_pc, taken, target_pc, is_incorrect,
                  input prediction, pre_pc, mispredict_cnt);
  modport slave (input fetch_pc, update_en, update_pc, taken, target_pc, is_incorrect,
                 output prediction, pre_pc, mispredict_cnt);
endinterface

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit saturating counters and mispredict count.
// Define BTB_GSHARE_EN to index the counter table with idx XOR global history.
module btb_predictor #(
  parameter int IDX_BITS = 5,
  parameter int TAG_BITS = 30 - IDX_BITS,
  parameter int GHR_BITS = 5
) (
  input logic   clk,
  input logic   reset_n,
  btb_if.slave  bus
);
  localparam int N = 1 << IDX_BITS;
  logic [N-1:0]          valid;
  logic [TAG_BITS-1:0]   tag_q [N];
  logic [31:0]           tgt_q [N];
  logic [1:0]            cnt_q [N];
  logic [31:0]           mcnt;
  logic [IDX_BITS-1:0]   f_idx, u_idx, f_cidx, u_cidx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;
  logic [1:0]            u_cnt, cnt_nx;
  assign f_idx = bus.fetch_pc[IDX_BITS+1:2];
  assign f_tag = bus.fetch_pc[31:IDX_BITS+2];
  assign u_idx = bus.update_pc[IDX_BITS+1:2];
  assign u_tag = bus.update_pc[31:IDX_BITS+2];
`ifdef BTB_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;
  assign f_cidx = f_idx ^ IDX_BITS'(ghr);
  assign u_cidx = u_idx ^ IDX_BITS'(ghr);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ghr <= '0;
    else if (bus.update_en) ghr <= GHR_BITS'({ghr, bus.taken});
`else
  assign f_cidx = f_idx;
  assign u_cidx = u_idx;
`endif
  always_comb begin
    f_hit  = valid[f_idx] && tag_q[f_idx] == f_tag;
    u_hit  = valid[u_idx] && tag_q[u_idx] == u_tag;
    u_cnt  = cnt_q[u_cidx];
    cnt_nx = bus.taken ? (u_cnt == 2'b11 ? u_cnt : u_cnt + 2'd1)
                       : (u_cnt == 2'b00 ? u_cnt : u_cnt - 2'd1);
  end
  // Lookup reads current contents only; updates land on the edge with no bypass.
  assign bus.prediction     = reset_n && f_hit && cnt_q[f_cidx][1];
  assign bus.pre_pc         = bus.prediction ? tgt_q[f_idx] : bus.fetch_pc + 32'd4;
  assign bus.mispredict_cnt = mcnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      valid <= '0;
      mcnt  <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else if (bus.update_en) begin
      if (bus.is_incorrect) mcnt <= mcnt + 32'd1;
      if (u_hit) begin
        cnt_q[u_cidx] <= cnt_nx;
        if (bus.taken) tgt_q[u_idx] <= bus.target_pc;
      end else if (bus.taken) begin
        valid[u_idx]  <= 1'b1;
        tag_q[u_idx]  <= u_tag;
        tgt_q[u_idx]  <= bus.target_pc;
        cnt_q[u_cidx] <= 2'b10;
      end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed checks of lookup, training, aliasing, hazard and async reset.
module tb_btb_predictor;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  btb_if bus();
  btb_predictor dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic p, input logic [31:0] npc);
    bus.fetch_pc = pc;
    #1;
    check({tag, "_pred"}, {31'd0, bus.prediction}, {31'd0, p});
    check({tag, "_pre_pc"}, bus.pre_pc, npc);
  endtask
  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic inc);
    bus.update_en = 1'b1;
    bus.update_pc = pc;
    bus.taken = t;
    bus.target_pc = tgt;
    bus.is_incorrect = inc;
    @(posedge clk);
    #1;
    bus.update_en = 1'b0;
    bus.is_incorrect = 1'b0;
  endtask
  initial begin
    bus.fetch_pc = 32'h0;
    bus.update_en = 1'b0;
    bus.update_pc = 32'h0;
    bus.taken = 1'b0;
    bus.target_pc = 32'h0;
    bus.is_incorrect = 1'b0;
    #2;
    look("in_reset", 32'h40, 1'b0, 32'h44);
    check("in_reset_mcnt", bus.mispredict_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    look("after_reset", 32'h40, 1'b0, 32'h44);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("after_reset_mcnt", bus.mispredict_cnt, 32'd0);
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    look("alloc", 32'h40, 1'b1, 32'h100);
    check("alloc_mcnt", bus.mispredict_cnt, 32'd1);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("sat_nt1", 32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0);
    look("sat_nt2", 32'h40, 1'b0, 32'h44);
    check("sat_mcnt", bus.mispredict_cnt, 32'd1);
    bus.is_incorrect = 1'b1;
    @(posedge clk);
    #1;
    bus.is_incorrect = 1'b0;
    check("inc_no_en_mcnt", bus.mispredict_cnt, 32'd1);
    upd(32'h40, 1'b1, 32'h180, 1'b1);
    look("retarget", 32'h40, 1'b1, 32'h180);
    check("retarget_mcnt", bus.mispredict_cnt, 32'd2);
    upd(32'hC0, 1'b1, 32'h200, 1'b0);
    look("alias_old", 32'h40, 1'b0, 32'h44);
    look("alias_new", 32'hC0, 1'b1, 32'h200);
    upd(32'h300, 1'b0, 32'h500, 1'b0);
    look("no_alloc_nt", 32'h300, 1'b0, 32'h304);
    bus.fetch_pc = 32'h80;
    bus.update_en = 1'b1;
    bus.update_pc = 32'h80;
    bus.taken = 1'b1;
    bus.target_pc = 32'h400;
    #1;
    check("hazard_same_pred", {31'd0, bus.prediction}, 32'd0);
    check("hazard_same_pre_pc", bus.pre_pc, 32'h84);
    @(posedge clk);
    #1;
    bus.update_en = 1'b0;
    check("hazard_next_pred", {31'd0, bus.prediction}, 32'd1);
    check("hazard_next_pre_pc", bus.pre_pc, 32'h400);
    upd(32'h40, 1'b1, 32'h111, 1'b0);
    look("pre_rst", 32'h40, 1'b1, 32'h111);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    look("rst_80", 32'h80, 1'b0, 32'h84);
    look("rst_40", 32'h40, 1'b0, 32'h44);
    look("rst_c0", 32'hC0, 1'b0, 32'hC4);
    check("rst_mcnt", bus.mispredict_cnt, 32'd0);
    bus.fetch_pc = 32'h100;
    upd(32'h100, 1'b1, 32'h700, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    look("dropped_upd", 32'h100, 1'b0, 32'h104);
    check("dropped_mcnt", bus.mispredict_cnt, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
